pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID/EX/WB datapath: drives PC write enable, IFID hold/flush and
//  IDEX bubble insertion. Detects RAW hazards between the instruction in ID and the
//  writers in EX and WB (no forwarding). Resolves control transfers by draining the
//  pipe until the branch/jump reaches WB. Keeps saturating stall/flush counters.
// PARAMETERS
//  OP_NOP    4'b0000  opcode; never causes a hazard or a drain
//  OP_J      4'b1000  jump
//  OP_BRZ    4'b1001  branch if zero
//  OP_BRN    4'b1010  branch if negative
//  OP_JM     4'b1110  jump through memory
//  CNT_W     16       width of performance counters
// PORTS
//  clock         in   1      rising-edge clock
//  reset_n       in   1      asynchronous active-low reset
//  id_opcode     in   4      opcode of instruction in IFID (ifidInstr[31:28])
//  id_rs         in   6      rs field in IFID
//  id_rt         in   6      rt field in IFID
//  ex_regwrt     in   1      instruction in IDEX writes the register file
//  ex_rd         in   6      its destination
//  wb_regwrt     in   1      instruction in EXWB writes the register file
//  wb_rd         in   6      its destination
//  wb_redirect   in   1      WB-stage PC redirect (bz|bn|jump|jumpmem, already gated)
//  pc_write      out  1      PC loads pcmux output this edge
//  ifid_write    out  1      IFID loads this edge (0 = hold)
//  ifid_flush    out  1      IFID loads NOP instead of imem output
//  idex_flush    out  1      IDEX loads bubble (all control bits 0)
//  ctl_busy      out  1      control transfer pending (state != RUN)
//  stall_cycles  out  CNT_W  cycles with data stall asserted, saturating
//  flush_cycles  out  CNT_W  cycles with ifid_flush asserted outside BOOT, saturating
// BEHAVIOUR
//  States: BOOT, RUN, BR_EX, BR_WB. Outputs combinational from state and inputs.
//  Reset (reset_n=0): state=BOOT, counters=0; pc_write=0, ifid_write=1,
//   ifid_flush=1, idex_flush=1, ctl_busy=1.
//  BOOT: one cycle after release; same outputs as reset; -> RUN.
//  hazard = id_opcode!=OP_NOP & ((ex_regwrt & (ex_rd==id_rs | ex_rd==id_rt)) |
//           (wb_regwrt & (wb_rd==id_rs | wb_rd==id_rt))). All non-NOP ops treated as
//           reading rs and rt (conservative). Register 0 is not special.
//  RUN, hazard: pc_write=0, ifid_write=0, idex_flush=1, stay RUN. Priority over ctl.
//   Producer in EX -> 2 stall cycles; producer in WB -> 1.
//  RUN, no hazard, id_opcode in {J,BRZ,BRN,JM}: pc_write=0, ifid_write=1,
//   ifid_flush=1 (kills branch+1), idex_flush=0 (branch enters IDEX) -> BR_EX.
//  RUN otherwise: pc_write=1, ifid_write=1, flushes 0.
//  BR_EX: pc_write=0, ifid_flush=1, idex_flush=1 -> BR_WB.
//  BR_WB: idex_flush=1; if wb_redirect: pc_write=1 (target), ifid_flush=1;
//   else pc_write=0, ifid_flush=0 (PC still branch+1; that instr enters IFID). -> RUN.
//  Hazard inputs ignored in BOOT/BR_EX/BR_WB (ID holds NOP there).
//  ifid_write=1 in all states except RUN-hazard.
//  Counters: +1 per qualifying cycle, hold at all-ones; not cleared except by reset.
//  Reset asserted mid-drain: immediate return to BOOT outputs; no residual state.
// TESTING
//  1 reset_n low 3 cycles, release -> BOOT 1 cycle (pc_write=0, ifid_flush=1), then
//    RUN with pc_write=1; counters 0.
//  2 ID rs=5, ex_regwrt=1 ex_rd=5; next cycle wb_rd=5 wb_regwrt=1 -> pc_write=0 and
//    idex_flush=1 both cycles, stall_cycles=2, third cycle pc_write=1.
//  3 ID opcode OP_BRZ, no hazard -> ifid_flush=1, pc_write=0, BR_EX, BR_WB;
//    wb_redirect=1 in BR_WB -> pc_write=1, ifid_flush=1, RUN next; ctl_busy high 2 cycles.
//  4 Same with wb_redirect=0 -> in BR_WB pc_write=0, ifid_flush=0; RUN next,
//    pc_write=1; total 3 cycles without PC advance.
//  5 OP_JM in ID with ex_rd==id_rt, ex_regwrt=1 -> stalls first (state stays RUN),
//    then drains; reset_n pulsed low during BR_EX -> BOOT outputs asynchronously.
//  6 Force 2^CNT_W+3 stall cycles -> stall_cycles saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: RAW stall detection against EX/WB writers and
// drain-to-WB resolution of control transfers, with saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [3:0]       id_opcode,
    input  logic [5:0]       id_rs,
    input  logic [5:0]       id_rt,
    input  logic             ex_regwrt,
    input  logic [5:0]       ex_rd,
    input  logic             wb_regwrt,
    input  logic [5:0]       wb_rd,
    input  logic             wb_redirect,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ctl_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_J   = 4'b1000;
    localparam logic [3:0] OP_BRZ = 4'b1001;
    localparam logic [3:0] OP_BRN = 4'b1010;
    localparam logic [3:0] OP_JM  = 4'b1110;

    // state | meaning
    // BOOT  | first cycle after reset, pipe filled with NOPs
    // RUN   | normal issue, data stalls handled here
    // BR_EX | control transfer in EX, keep killing fetches
    // BR_WB | control transfer in WB, redirect or resume at branch+1
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        BR_EX = 2'd2,
        BR_WB = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   hazard;
    logic   is_ctl;
    logic   stall;

    assign hazard = (id_opcode != OP_NOP) &&
                    ((ex_regwrt && (ex_rd == id_rs || ex_rd == id_rt)) ||
                     (wb_regwrt && (wb_rd == id_rs || wb_rd == id_rt)));

    assign is_ctl = (id_opcode == OP_J) || (id_opcode == OP_BRZ) ||
                    (id_opcode == OP_BRN) || (id_opcode == OP_JM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_write   = 1'b0;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        stall      = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (hazard) begin
                    // Data stall wins over a control op sitting in ID.
                    ifid_write = 1'b0;
                    ifid_flush = 1'b0;
                    stall      = 1'b1;
                end else if (is_ctl) begin
                    idex_flush = 1'b0;
                    state_nxt  = BR_EX;
                end else begin
                    pc_write   = 1'b1;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                end
            end
            BR_EX: begin
                state_nxt = BR_WB;
            end
            BR_WB: begin
                pc_write   = wb_redirect;
                ifid_flush = wb_redirect;
                state_nxt  = RUN;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign ctl_busy = (state != RUN);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (ifid_flush && (state != BOOT) && !(&flush_cycles)) begin
                flush_cycles <= flush_cycles + 1'b1;
            end
        end
    end

endmodule
